companion_step_engine: RTL and testbench
========================================

Name: companion_step_engine

Overview:
- Per-timestep update engine for the FPGA circuit simulator.
- Computes the companion-model history currents of N reactive elements (inductors and capacitors) in fixed point, using one shared multiplier sequenced over the channels.
- Also generates the square-wave source value E, which toggles every HALF_PERIOD completed timesteps.
- Sits between the node-voltage solver and the right-hand-side (z vector) assembly; one start pulse equals one simulation timestep.

Parameters:
- WIDTH, 16, signed fixed-point word width (two's complement).
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC).
- N_ELEM, 2, number of reactive channels, 1..16.
- HALF_PERIOD, 8, completed steps between source toggles, ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting one timestep; honoured only in IDLE.
- elem_type  in  N_ELEM  per channel: 0 = inductor (L), 1 = capacitor (C).
- k_coef  in  N_ELEM*WIDTH  per-channel coefficient (L: T/L, C: 4C/T), packed with channel 0 in the LSBs.
- v_diff  in  N_ELEM*WIDTH  per-channel branch voltage (v1-v2), same packing.
- e_amp  in  WIDTH  source amplitude.
- hist  out  N_ELEM*WIDTH  history currents, registered.
- e_out  out  WIDTH  source value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a timestep.

Behaviour:
- Reset: all hist entries = 0, e_out = 0, busy = 0, done = 0, step counter = 0, phase = 0, FSM = IDLE. Reset overrides everything, including mid-step; a partially updated hist is discarded, not retained.
- FSM states and transitions:
  - IDLE: start=1 latches k_coef, v_diff and elem_type into internal registers, sets ch = 0, goes to MUL.
  - MUL: registers the full 2*WIDTH signed product k[ch]*v[ch], goes to ACC.
  - ACC: updates hist[ch]. If ch = N_ELEM-1, go to DONE; otherwise ch++ and go to MUL.
  - DONE: done = 1 for this cycle, source update, return to IDLE.
- Latency: start accepted in cycle t -> done high in cycle t+2*N_ELEM+1. hist[ch] is visible from the cycle after its ACC. busy is high from t+1 through the DONE cycle inclusive.
- start while not in IDLE is ignored; there is no queueing. Inputs may change after the accept cycle without effect.
- Arithmetic:
  - p = (k*v) >>> FRAC, arithmetic shift (rounds toward -inf), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - L channel: hist_new = sat(hist_old + p).
  - C channel: hist_new = sat(-hist_old + p). Negation of the most-negative value saturates to the most-positive value.
  - All sums are computed at WIDTH+1 bits, then saturated.
- Source update in DONE:
  - If count = HALF_PERIOD-1: count = 0 and phase toggles; else count++.
  - e_out = phase ? e_amp : 0, using the new phase and e_amp sampled in the DONE cycle.
  - HALF_PERIOD = 1 toggles on every step.
- elem_type is latched per step; changing it between steps is legal.

Decomposition:
- Package circsim_pkg holds:
  - ELEM_L = 1'b0 and ELEM_C = 1'b1
  - FSM state encoding (IDLE, MUL, ACC, DONE)
  - a saturate function (width-generic via WIDTH+1 input).
- Sub-module fxp_mul_sat: registered signed multiply, >>> FRAC, saturate to WIDTH. It is the single shared multiplier, instantiated once.

Test Plan (WIDTH=16, FRAC=8, N_ELEM=2, HALF_PERIOD=8):
- Inductor accumulation: ch0 L, k=0x0080, v=0x0200, two steps -> hist0 = 0x0100, then 0x0200. done at start+5 both times.
- Capacitor alternation: ch1 C, k=0x0400, v=0x0100 -> hist1 = 0x0400 after step 1, 0x0000 after step 2. Also ch0 L, k=0x0100, v=0xFF00 -> hist0 = 0xFF00.
- Saturation: L with k=0x7FFF, v=0x7FFF -> hist = 0x7FFF. C with hist_old=0x8000, p=0 -> 0x7FFF. Large negative product -> 0x8000.
- Source: e_amp=0x0500 -> e_out = 0 through done of step 7, 0x0500 after done of step 8, 0 after done of step 16.
- Handshake: start pulsed again at start+2 -> ignored, exactly one done. start held high for 10 cycles -> two steps, each done at the expected cycle.
- Reset mid-step: assert rst during the ACC of ch0 -> next cycle busy=0, all hist=0, e_out=0, count restarts; the next start behaves as the first step.

Source files
------------

// File: rtl/circsim_pkg.sv
// Shared types and helpers for the circuit-simulator timestep datapath.
// Element kinds, step FSM encoding and a width-generic saturation test.
package circsim_pkg;

    localparam logic ELEM_L = 1'b0;
    localparam logic ELEM_C = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACC,
        ST_DONE
    } state_t;

    // Returns {above max, below min} for a sign-extended value against a w-bit range.
    function automatic logic [1:0] sat_flags(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return {x > hi, x < lo};
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Shared registered fixed-point multiplier.
// Product is shifted right by FRAC (toward -inf) and clamped to WIDTH bits.
module fxp_mul_sat
    import circsim_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_p
);

    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [2*WIDTH-1:0] w_shift;
    logic signed [63:0]        w_wide;
    logic        [1:0]         w_flags;
    logic signed [WIDTH-1:0]   r_p;

    assign w_prod  = i_a * i_b;
    assign w_shift = w_prod >>> FRAC;
    assign w_wide  = {{(64-2*WIDTH){w_shift[2*WIDTH-1]}}, w_shift};
    assign w_flags = sat_flags(w_wide, WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= w_flags[1] ? MAXV :
                   w_flags[0] ? MINV : w_shift[WIDTH-1:0];
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/companion_step_engine.sv
// Per-timestep companion-model history update for L/C channels,
// sequenced over one shared multiplier, plus the square-wave source.
module companion_step_engine
    import circsim_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 8,
    parameter int N_ELEM      = 2,
    parameter int HALF_PERIOD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_ELEM-1:0]         elem_type,
    input  logic [N_ELEM*WIDTH-1:0]   k_coef,
    input  logic [N_ELEM*WIDTH-1:0]   v_diff,
    input  logic [WIDTH-1:0]          e_amp,
    output logic [N_ELEM*WIDTH-1:0]   hist,
    output logic [WIDTH-1:0]          e_out,
    output logic                      busy,
    output logic                      done
);

    localparam int CHW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CHW-1:0] LAST_CH  = CHW'(N_ELEM - 1);
    localparam logic [CNW-1:0] LAST_CNT = CNW'(HALF_PERIOD - 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                    r_state;
    logic [CHW-1:0]            r_ch;
    logic [N_ELEM-1:0]         r_type;
    logic [N_ELEM*WIDTH-1:0]   r_k;
    logic [N_ELEM*WIDTH-1:0]   r_v;
    logic [N_ELEM*WIDTH-1:0]   r_hist;
    logic [CNW-1:0]            r_cnt;
    logic                      r_phase;
    logic [WIDTH-1:0]          r_e;
    logic                      r_busy;
    logic                      r_done;

    logic signed [WIDTH-1:0]   w_k;
    logic signed [WIDTH-1:0]   w_v;
    logic signed [WIDTH-1:0]   w_p;
    logic signed [WIDTH-1:0]   w_old;
    logic signed [WIDTH:0]     w_old_x;
    logic signed [WIDTH:0]     w_p_x;
    logic signed [WIDTH:0]     w_term;
    logic signed [WIDTH:0]     w_sum;
    logic signed [63:0]        w_wide;
    logic        [1:0]         w_flags;
    logic        [WIDTH-1:0]   w_new;
    logic                      w_mul_en;
    logic                      w_wrap;
    logic                      w_phase_nx;

    assign w_k      = r_k[r_ch*WIDTH +: WIDTH];
    assign w_v      = r_v[r_ch*WIDTH +: WIDTH];
    assign w_mul_en = (r_state == ST_MUL);

    fxp_mul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_mul_en),
        .i_a  (w_k),
        .i_b  (w_v),
        .o_p  (w_p)
    );

    // Capacitor history flips sign each step; -MIN fits at WIDTH+1 bits.
    assign w_old   = r_hist[r_ch*WIDTH +: WIDTH];
    assign w_old_x = {w_old[WIDTH-1], w_old};
    assign w_p_x   = {w_p[WIDTH-1], w_p};
    assign w_term  = (r_type[r_ch] == ELEM_C) ? -w_old_x : w_old_x;
    assign w_sum   = w_term + w_p_x;
    assign w_wide  = {{(63-WIDTH){w_sum[WIDTH]}}, w_sum};
    assign w_flags = sat_flags(w_wide, WIDTH);
    assign w_new   = w_flags[1] ? MAXV :
                     w_flags[0] ? MINV : w_sum[WIDTH-1:0];

    assign w_wrap     = (r_cnt == LAST_CNT);
    assign w_phase_nx = w_wrap ? ~r_phase : r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_type  <= '0;
            r_k     <= '0;
            r_v     <= '0;
            r_hist  <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_e     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_type  <= elem_type;
                        r_k     <= k_coef;
                        r_v     <= v_diff;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_hist[r_ch*WIDTH +: WIDTH] <= w_new;
                    if (r_ch == LAST_CH) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    r_cnt   <= w_wrap ? '0 : r_cnt + CNW'(1);
                    r_phase <= w_phase_nx;
                    r_e     <= w_phase_nx ? e_amp : '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hist  = r_hist;
    assign e_out = r_e;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_companion_step_engine.sv
// Directed bench for companion_step_engine with hand-computed expectations.
// Covers L/C updates, saturation, source toggling, handshake and reset.
module tb_companion_step_engine;

    localparam int W = 16;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   elem_type;
    logic [N*W-1:0] k_coef;
    logic [N*W-1:0] v_diff;
    logic [W-1:0]   e_amp;
    logic [N*W-1:0] hist;
    logic [W-1:0]   e_out;
    logic           busy;
    logic           done;

    int n_chk  = 0;
    int n_pass = 0;

    companion_step_engine #(
        .WIDTH       (W),
        .FRAC        (8),
        .N_ELEM      (N),
        .HALF_PERIOD (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .elem_type (elem_type),
        .k_coef    (k_coef),
        .v_diff    (v_diff),
        .e_amp     (e_amp),
        .hist      (hist),
        .e_out     (e_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] h(input int c);
        return hist[c*W +: W];
    endfunction

    task automatic pulse_rst();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One timestep; inputs are scrambled after accept to prove latching.
    task automatic step(input logic [1:0] ty, input logic [15:0] k0,
                        input logic [15:0] v0, input logic [15:0] k1,
                        input logic [15:0] v1);
        int n;
        @(negedge clk);
        elem_type = ty;
        k_coef    = {k1, k0};
        v_diff    = {v1, v0};
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        elem_type = ~ty;
        k_coef    = '1;
        v_diff    = '1;
        check("busy_on", busy, 1);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 5);
        @(negedge clk);
        check("busy_off", busy, 0);
    endtask

    initial begin
        int dn;
        int t1;
        int t2;
        rst       = 1'b1;
        start     = 1'b0;
        elem_type = '0;
        k_coef    = '0;
        v_diff    = '0;
        e_amp     = 16'h0500;
        repeat (2) @(negedge clk);
        check("rst_hist", hist, 0);
        check("rst_eout", e_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Inductor accumulation
        step(2'b00, 16'h0080, 16'h0200, 16'h0000, 16'h0000);
        check("L_step1_h0", h(0), 16'h0100);
        check("L_step1_h1", h(1), 16'h0000);
        step(2'b00, 16'h0080, 16'h0200, 16'h0000, 16'h0000);
        check("L_step2_h0", h(0), 16'h0200);

        // Capacitor alternation with negative inductor drive
        pulse_rst();
        step(2'b10, 16'h0100, 16'hFF00, 16'h0400, 16'h0100);
        check("C_step1_h0", h(0), 16'hFF00);
        check("C_step1_h1", h(1), 16'h0400);
        step(2'b10, 16'h0100, 16'hFF00, 16'h0400, 16'h0100);
        check("C_step2_h0", h(0), 16'hFE00);
        check("C_step2_h1", h(1), 16'h0000);

        // Saturation
        pulse_rst();
        step(2'b10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000);
        check("sat_pos_L", h(0), 16'h7FFF);
        check("sat_neg_C", h(1), 16'h8000);
        step(2'b10, 16'h0000, 16'h1234, 16'h0000, 16'h1234);
        check("sat_hold_L", h(0), 16'h7FFF);
        check("sat_negmin_C", h(1), 16'h7FFF);

        // Square-wave source
        pulse_rst();
        for (int i = 1; i <= 16; i++) begin
            step(2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
            check($sformatf("src_step%0d", i), e_out,
                  (i >= 8 && i < 16) ? 32'h0500 : 32'h0000);
        end

        // Start re-pulsed mid-step is ignored
        pulse_rst();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        dn = 0;
        for (int i = 1; i <= 14; i++) begin
            if (done) dn++;
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("repulse_one_done", dn, 1);

        // Start held high for 10 cycles -> two back-to-back steps
        @(negedge clk);
        start = 1'b1;
        dn = 0;
        t1 = 0;
        t2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) start = 1'b0;
            if (done) begin
                dn++;
                if (dn == 1) t1 = i + 1;
                else t2 = i + 1;
            end
        end
        check("held_dones", dn, 2);
        check("held_done1_cyc", t1, 5);
        check("held_done2_cyc", t2, 11);

        // Reset during ACC of ch0
        pulse_rst();
        for (int i = 0; i < 9; i++)
            step(2'b00, 16'h0080, 16'h0200, 16'h0000, 16'h0000);
        check("pre_rst_h0", h(0), 16'h0900);
        check("pre_rst_eout", e_out, 16'h0500);
        @(negedge clk);
        elem_type = 2'b00;
        k_coef    = {16'h0000, 16'h0080};
        v_diff    = {16'h0000, 16'h0200};
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hist", hist, 0);
        check("midrst_eout", e_out, 0);
        for (int i = 1; i <= 8; i++) begin
            step(2'b00, 16'h0080, 16'h0200, 16'h0000, 16'h0000);
            if (i == 1) check("post_rst_h0", h(0), 16'h0100);
            if (i == 7) check("post_rst_e7", e_out, 16'h0000);
            if (i == 8) check("post_rst_e8", e_out, 16'h0500);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
